// File: rtl/frame_chk_pkg.sv
// Shared definitions for the frame timing checker: error bit indices,
// tracking state encoding and the beats-per-line helper.
package frame_chk_pkg;

  localparam int ERR_EOL_EARLY = 0;
  localparam int ERR_EOL_LATE  = 1;
  localparam int ERR_SOF_EARLY = 2;
  localparam int ERR_SOF_LATE  = 3;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DONE     = 2'd2
  } state_e;

  // Beats needed to carry hsize pixels at 2**ppc_log2 pixels per beat,
  // rounding a partial last beat up.
  function automatic logic [31:0] beats_per_line(input logic [31:0] hsize,
                                                 input int unsigned ppc_log2);
    logic [31:0] round_up;
    round_up = (32'd1 << ppc_log2) - 32'd1;
    return (hsize + round_up) >> ppc_log2;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Clear wins over increment; increment stops at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/frame_timing_checker.sv
// Passive AXI4-Stream video frame-timing checker. Tracks line/beat position
// from SOF (tuser) and EOL (tlast) markers and reports early/late line ends
// and early/late frame starts with pulses, sticky bits, saturating counters
// and a snapshot of the first offending beat.
module frame_timing_checker
  import frame_chk_pkg::*;
#(
  parameter  int MAX_HSIZE = 4096,
  parameter  int MAX_VSIZE = 2160,
  parameter  int PPC       = 1,
  parameter  int ERR_CNT_W = 16,
  localparam int HW        = $clog2(MAX_HSIZE) + 1,
  localparam int VW        = $clog2(MAX_VSIZE) + 1
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic [HW-1:0]          hsize,
  input  logic [VW-1:0]          vsize,
  input  logic                   clr,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [3:0]             err_flag,
  output logic [3:0]             err_latch,
  output logic [4*ERR_CNT_W-1:0] err_cnt,
  output logic                   first_err_valid,
  output logic [3:0]             first_err_type,
  output logic [31:0]            first_err_frame,
  output logic [VW-1:0]          first_err_line,
  output logic [HW-1:0]          first_err_beat,
  output logic [31:0]            frame_cnt,
  output logic [VW-1:0]          line_cnt,
  output logic [HW-1:0]          beat_cnt,
  output logic                   synced
);

  localparam int unsigned PPC_LOG2 = $clog2(PPC);

  state_e        state_q, state_d;
  logic [31:0]   frame_q;
  logic [VW-1:0] line_q, vsize_q;
  logic [HW-1:0] beat_q, bpl_q;
  logic          synced_q;

  logic [3:0]    err_d, err_flag_q, err_latch_q;
  logic          fe_valid_q;
  logic [3:0]    fe_type_q;
  logic [31:0]   fe_frame_q;
  logic [VW-1:0] fe_line_q;
  logic [HW-1:0] fe_beat_q;

  logic          beat_s, sof_s, tracked_s;
  logic [HW-1:0] bpl_in_s, pos_bpl_s, pos_beat_s;
  logic [VW-1:0] pos_line_s, pos_vsize_s;
  logic [31:0]   pos_frame_s;

  assign bpl_in_s = HW'(beats_per_line(32'(hsize), PPC_LOG2));

  // Position and size context of the current beat (an SOF beat restarts at
  // line 0 / beat 0 with freshly sampled sizes) and the error events it raises.
  always_comb begin
    beat_s      = s_axis_tvalid & s_axis_tready;
    sof_s       = beat_s & s_axis_tuser;
    tracked_s   = beat_s & (s_axis_tuser | (state_q == ACTIVE));
    pos_line_s  = sof_s ? '0 : line_q;
    pos_beat_s  = sof_s ? '0 : beat_q;
    pos_bpl_s   = sof_s ? bpl_in_s : bpl_q;
    pos_vsize_s = sof_s ? vsize : vsize_q;
    pos_frame_s = sof_s ? (frame_q + 32'd1) : frame_q;
    err_d                = 4'b0000;
    err_d[ERR_EOL_EARLY] = tracked_s & s_axis_tlast & (pos_beat_s < (pos_bpl_s - 1'b1));
    err_d[ERR_EOL_LATE]  = tracked_s & ~s_axis_tlast & (pos_beat_s == (pos_bpl_s - 1'b1));
    err_d[ERR_SOF_EARLY] = sof_s & (state_q == ACTIVE);
    err_d[ERR_SOF_LATE]  = beat_s & ~s_axis_tuser & (state_q == DONE);
  end

  // Next tracking state: tracked beats stay ACTIVE until the last line ends,
  // any stray beat after the last line forces a resync.
  always_comb begin
    state_d = state_q;
    if (tracked_s) begin
      state_d = (s_axis_tlast && (pos_line_s == (pos_vsize_s - 1'b1))) ? DONE : ACTIVE;
    end else if (beat_s && (state_q == DONE)) begin
      state_d = WAIT_SOF;
    end else if ((state_q != WAIT_SOF) && (state_q != ACTIVE) && (state_q != DONE)) begin
      state_d = WAIT_SOF;
    end else begin
      state_d = state_q;
    end
  end

  // Tracking FSM with frame/line/beat position counters and held frame sizes.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= WAIT_SOF;
      synced_q <= 1'b0;
      frame_q  <= '0;
      line_q   <= '0;
      beat_q   <= '0;
      vsize_q  <= '0;
      bpl_q    <= '0;
    end else begin
      state_q  <= state_d;
      synced_q <= (state_d != WAIT_SOF);
      if (sof_s) begin
        frame_q <= frame_q + 32'd1;
        vsize_q <= vsize;
        bpl_q   <= bpl_in_s;
      end
      if (tracked_s) begin
        if (s_axis_tlast) begin
          line_q <= pos_line_s + 1'b1;
          beat_q <= '0;
        end else if (pos_beat_s != '1) begin
          line_q <= pos_line_s;
          beat_q <= pos_beat_s + 1'b1;
        end else begin
          line_q <= pos_line_s;
          beat_q <= pos_beat_s;
        end
      end
    end
  end

  // Error pulses, sticky bits and first-error snapshot; clr empties the
  // sticky state but never suppresses the pulse.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      err_flag_q  <= '0;
      err_latch_q <= '0;
      fe_valid_q  <= 1'b0;
      fe_type_q   <= '0;
      fe_frame_q  <= '0;
      fe_line_q   <= '0;
      fe_beat_q   <= '0;
    end else begin
      err_flag_q <= err_d;
      if (clr) begin
        err_latch_q <= '0;
        fe_valid_q  <= 1'b0;
        fe_type_q   <= '0;
        fe_frame_q  <= '0;
        fe_line_q   <= '0;
        fe_beat_q   <= '0;
      end else begin
        err_latch_q <= err_latch_q | err_d;
        if ((err_d != 4'b0000) && !fe_valid_q) begin
          fe_valid_q <= 1'b1;
          fe_type_q  <= err_d;
          fe_frame_q <= pos_frame_s;
          fe_line_q  <= pos_line_s;
          fe_beat_q  <= pos_beat_s;
        end
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_err_cnt
    sat_counter #(.W(ERR_CNT_W)) u_cnt (
      .clk_i  (aclk),
      .rst_ni (resetn),
      .clr_i  (clr),
      .inc_i  (err_d[i]),
      .cnt_o  (err_cnt[i*ERR_CNT_W +: ERR_CNT_W])
    );
  end

  assign err_flag        = err_flag_q;
  assign err_latch       = err_latch_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_type  = fe_type_q;
  assign first_err_frame = fe_frame_q;
  assign first_err_line  = fe_line_q;
  assign first_err_beat  = fe_beat_q;
  assign frame_cnt       = frame_q;
  assign line_cnt        = line_q;
  assign beat_cnt        = beat_q;
  assign synced          = synced_q;

endmodule

// File: tb/tb_frame_timing_checker.sv
// Directed bench for frame_timing_checker (hsize=8, vsize=4, PPC=2: 4 beats
// per line) with a behavioural reference model compared on every cycle.
module tb_frame_timing_checker;

  localparam int MAX_HSIZE = 4096;
  localparam int MAX_VSIZE = 2160;
  localparam int PPC       = 2;
  localparam int CW        = 8;
  localparam int HW        = $clog2(MAX_HSIZE) + 1;
  localparam int VW        = $clog2(MAX_VSIZE) + 1;
  localparam int BEAT_MAX  = (1 << HW) - 1;
  localparam int CNT_MAX   = (1 << CW) - 1;
  localparam int M_WAIT = 0, M_ACT = 1, M_DONE = 2;

  logic aclk = 1'b0;
  logic resetn = 1'b0;
  logic [HW-1:0] hsize;
  logic [VW-1:0] vsize;
  logic clr = 1'b0, s_v = 1'b0, s_r = 1'b0, s_l = 1'b0, s_u = 1'b0;
  logic [3:0] err_flag, err_latch, first_err_type;
  logic [4*CW-1:0] err_cnt;
  logic first_err_valid, synced;
  logic [31:0] first_err_frame, frame_cnt;
  logic [VW-1:0] first_err_line, line_cnt;
  logic [HW-1:0] first_err_beat, beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_state, m_line, m_beat, m_hs, m_vs;
  logic [31:0] m_frame;
  logic [3:0]  m_flag, m_latch, m_ftype;
  logic [CW-1:0] m_cnt [4];
  logic        m_fv;
  logic [31:0] m_fframe;
  int          m_fline, m_fbeat;

  frame_timing_checker #(
    .MAX_HSIZE(MAX_HSIZE), .MAX_VSIZE(MAX_VSIZE), .PPC(PPC), .ERR_CNT_W(CW)
  ) dut (
    .aclk(aclk), .resetn(resetn), .hsize(hsize), .vsize(vsize), .clr(clr),
    .s_axis_tvalid(s_v), .s_axis_tready(s_r), .s_axis_tlast(s_l), .s_axis_tuser(s_u),
    .err_flag(err_flag), .err_latch(err_latch), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_type(first_err_type),
    .first_err_frame(first_err_frame), .first_err_line(first_err_line),
    .first_err_beat(first_err_beat), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
    .beat_cnt(beat_cnt), .synced(synced)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_WAIT; m_line = 0; m_beat = 0; m_hs = 0; m_vs = 0; m_frame = '0;
    m_flag = '0; m_latch = '0; m_fv = 1'b0; m_ftype = '0; m_fframe = '0;
    m_fline = 0; m_fbeat = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
  endtask

  // Apply the frame-timing rules to the inputs present at this clock edge.
  task automatic model_step();
    logic [3:0] ev;
    int bpl, p_line, p_beat;
    logic [31:0] p_frame;
    ev = 4'b0000;
    p_line = m_line; p_beat = m_beat; p_frame = m_frame;
    if (s_v && s_r) begin
      if (s_u) begin
        if (m_state == M_ACT) ev[2] = 1'b1;
        m_frame = m_frame + 32'd1;
        m_hs = int'(hsize); m_vs = int'(vsize);
        m_line = 0; m_beat = 0; m_state = M_ACT;
      end else if (m_state == M_DONE) begin
        ev[3] = 1'b1;
        m_state = M_WAIT;
      end
      p_line = m_line; p_beat = m_beat; p_frame = m_frame;
      if (m_state == M_ACT) begin
        bpl = (m_hs + PPC - 1) / PPC;
        if (s_l && m_beat < bpl - 1) ev[0] = 1'b1;
        if (!s_l && m_beat == bpl - 1) ev[1] = 1'b1;
        if (s_l) begin
          if (m_line == m_vs - 1) m_state = M_DONE;
          m_line++;
          m_beat = 0;
        end else if (m_beat < BEAT_MAX) begin
          m_beat++;
        end
      end
    end
    m_flag = ev;
    if (clr) begin
      m_latch = '0; m_fv = 1'b0; m_ftype = '0; m_fframe = '0; m_fline = 0; m_fbeat = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = '0;
    end else begin
      m_latch = m_latch | ev;
      for (int i = 0; i < 4; i++)
        if (ev[i] && m_cnt[i] != CNT_MAX[CW-1:0]) m_cnt[i] = m_cnt[i] + 1'b1;
      if (ev != 4'b0000 && !m_fv) begin
        m_fv = 1'b1; m_ftype = ev; m_fframe = p_frame; m_fline = p_line; m_fbeat = p_beat;
      end
    end
  endtask

  // One clock cycle with the given inputs; returns #1 after the edge.
  task automatic drive(input bit v, input bit r, input bit l, input bit u, input bit c);
    s_v = v; s_r = r; s_l = l; s_u = u; clr = c;
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    s_v = 1'b0; s_r = 1'b0; s_l = 1'b0; s_u = 1'b0; clr = 1'b0;
    resetn = 1'b0;
    model_reset();
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    resetn = 1'b1;
  endtask

  task automatic send_line(input int n, input int last_idx, input bit sof, input bit stalls);
    for (int b = 0; b < n; b++) begin
      if (stalls) begin
        case ($urandom_range(0, 2))
          0: ;
          1: drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
          default: drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        endcase
      end
      drive(1'b1, 1'b1, b == last_idx, sof && (b == 0), 1'b0);
    end
  endtask

  task automatic send_frame(input bit stalls);
    for (int l = 0; l < 4; l++) send_line(4, 3, l == 0, stalls);
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge aclk);
      check("err_flag", err_flag, m_flag);
      check("err_latch", err_latch, m_latch);
      check("err_cnt", err_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
      check("first_err_valid", first_err_valid, m_fv);
      check("first_err_type", first_err_type, m_ftype);
      check("first_err_frame", first_err_frame, m_fframe);
      check("first_err_line", first_err_line, 64'(m_fline));
      check("first_err_beat", first_err_beat, 64'(m_fbeat));
      check("frame_cnt", frame_cnt, m_frame);
      check("line_cnt", line_cnt, 64'(m_line));
      check("beat_cnt", beat_cnt, 64'(m_beat));
      check("synced", synced, m_state != M_WAIT);
    end
  end

  initial begin
    hsize = HW'(8);
    vsize = VW'(4);
    model_reset();
    do_reset();
    check("rst_frame", frame_cnt, 64'd0);
    check("rst_synced", synced, 64'd0);
    check("rst_latch", err_latch, 64'd0);
    check("rst_cnt", err_cnt, 64'd0);
    check("rst_line_beat", {line_cnt, beat_cnt}, 64'd0);

    // two clean frames with stalls
    send_frame(1'b1);
    send_frame(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clean_frames", frame_cnt, 64'd2);
    check("clean_latch", err_latch, 64'd0);
    check("clean_done_line", line_cnt, 64'd4);
    check("clean_synced", synced, 64'd1);

    // beats before first SOF are ignored
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("presof_synced", synced, 64'd0);
    check("presof_frame", frame_cnt, 64'd0);
    check("presof_flag", err_flag, 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sof_synced", synced, 64'd1);
    check("sof_beat", beat_cnt, 64'd1);
    send_line(3, 2, 1'b0, 1'b0);
    for (int l = 1; l < 4; l++) send_line(4, 3, 1'b0, 1'b0);
    check("presof_latch", err_latch, 64'd0);

    // early EOL on line 1 beat 2
    do_reset();
    send_line(4, 3, 1'b1, 1'b0);
    send_line(3, 2, 1'b0, 1'b0);
    check("eole_flag", err_flag, 64'h1);
    check("eole_snap", {first_err_valid, first_err_type}, 64'h11);
    check("eole_snap_frame", first_err_frame, 64'd1);
    check("eole_snap_line", first_err_line, 64'd1);
    check("eole_snap_beat", first_err_beat, 64'd2);
    check("eole_line_cnt", line_cnt, 64'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("eole_pulse_end", err_flag, 64'd0);
    send_line(4, 3, 1'b0, 1'b0);
    send_line(4, 3, 1'b0, 1'b0);

    // overlong line 0: 6 beats, tlast on the 6th
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 6; b++) begin
      drive(1'b1, 1'b1, b == 5, b == 0, 1'b0);
      if (b == 3) check("eoll_flag", err_flag, 64'h2);
      if (b == 4) check("eoll_once", err_flag, 64'h0);
    end
    check("eoll_end", {line_cnt, beat_cnt}, {51'd0, 13'd0} | 64'(1 << HW));
    send_line(4, 3, 1'b0, 1'b0);
    check("eoll_cnt", err_cnt, 64'h0000_0100);
    check("eoll_next_line", line_cnt, 64'd2);
    send_line(4, 3, 1'b0, 1'b0);
    send_line(4, 3, 1'b0, 1'b0);

    // early SOF on line 2, then a frame with an extra line
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_line(4, 3, 1'b1, 1'b0);
    send_line(4, 3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sofe_flag", err_flag, 64'h4);
    check("sofe_frame", frame_cnt, 64'd4);
    check("sofe_restart", {line_cnt, beat_cnt}, 64'd1);
    send_line(3, 2, 1'b0, 1'b0);
    for (int l = 1; l < 4; l++) send_line(4, 3, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sofl_flag", err_flag, 64'h8);
    check("sofl_synced", synced, 64'd0);
    send_line(3, 2, 1'b0, 1'b0);
    check("sofl_latch", err_latch, 64'hC);
    check("sofl_cnt", err_cnt, 64'h0101_0000);

    // counter saturation, then clr coincident with an error
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < (1 << CW) + 3; k++) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("sat_eole", err_cnt[CW-1:0], 64'(CNT_MAX));
    check("sat_sofe", err_cnt[3*CW-1:2*CW], 64'(CNT_MAX));
    check("sat_first_type", first_err_type, 64'h1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_flag", err_flag, 64'h5);
    check("clr_latch", err_latch, 64'd0);
    check("clr_cnt", err_cnt, 64'd0);
    check("clr_snap", {first_err_valid, first_err_type}, 64'd0);
    check("clr_frame", frame_cnt, 64'd264);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_pulse_end", err_flag, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_timing_checker.md
# frame_timing_checker

Parametrised, self-contained AXI4-Stream video frame-timing checker: next-generation frame-size error checker. It owns its pixel/line/frame counters and supports multiple pixels per clock. It resynchronises on SOF and keeps per-error saturating counters plus a first-error snapshot. It taps a video stream passively (monitors tvalid/tready only) inside the video debug module and feeds the debug register file.

## Interface
Parameters:
- MAX_HSIZE, 4096, max active pixels per line
- MAX_VSIZE, 2160, max active lines per frame
- PPC, 1, pixels per beat (1, 2 or 4)
- ERR_CNT_W, 16, width of each error event counter

Widths: HW = $clog2(MAX_HSIZE)+1, VW = $clog2(MAX_VSIZE)+1.

Ports:
- aclk  in  1  single clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- hsize  in  HW  expected pixels per line, ≥1
- vsize  in  VW  expected lines per frame, ≥1
- clr  in  1  synchronous pulse: clear latches, counters, snapshot
- s_axis_tvalid / s_axis_tready / s_axis_tlast / s_axis_tuser  in  1 each  monitored stream
- err_flag  out  4  one-cycle pulse per error; bit 0 eol_early, 1 eol_late, 2 sof_early, 3 sof_late
- err_latch  out  4  sticky per-type error bits
- err_cnt  out  4*ERR_CNT_W  saturating event counters, type i at [i*ERR_CNT_W +: ERR_CNT_W]
- first_err_valid  out  1  snapshot valid
- first_err_type  out  4  err bits of first erroneous beat
- first_err_frame / first_err_line / first_err_beat  out  32 / VW / HW  position of that beat
- frame_cnt  out  32  SOF beats accepted, wraps
- line_cnt / beat_cnt  out  VW / HW  position of next expected beat
- synced  out  1  high in ACTIVE or DONE

## Operation
- Beat = cycle with tvalid & tready. All other cycles are ignored.
- beats_per_line = ceil(hsize/PPC). PPC is a power of two, so this is a shift-and-round. hsize and vsize are sampled into internal registers on every SOF beat and held for the frame.
- States:
  - WAIT_SOF: reset state. Non-SOF beats are ignored, no errors. A tuser beat goes to ACTIVE.
  - ACTIVE: counting lines and beats.
  - DONE: line vsize-1 has ended.
- Any tuser beat: frame_cnt += 1. That beat is (line 0, beat 0). The size registers reload.
- ACTIVE beat with tlast: line_cnt += 1, beat_cnt = 0. If the ended line was vsize-1, go to DONE. Otherwise beat_cnt += 1, saturating at all-ones.
- eol_early: tlast on a beat with beat index < beats_per_line-1.
- eol_late: a beat with beat index == beats_per_line-1 and no tlast. Flagged once per line. Further beats of the overlong line are not re-flagged.
- sof_early: tuser beat in ACTIVE. The frame restarts at this beat.
- sof_late: non-tuser beat in DONE. Go to WAIT_SOF (resync). Flagged once.
- A tuser beat in DONE is normal and goes to ACTIVE.
- Simultaneous events are all flagged in the same cycle. Example: tuser+tlast on a short line sets sof_early and eol_early.
- Counters saturate at 2^ERR_CNT_W-1.
- The snapshot captures the first beat with any error since reset/clr. Its type field holds all bits set on that beat.
- clr has priority over latch, counter and snapshot updates in the same cycle. err_flag still pulses. clr does not affect state, line_cnt, beat_cnt or frame_cnt.

## Timing
- Latency: err_flag, err_latch, err_cnt and the snapshot update on the edge ending the offending beat. They are visible the next cycle. err_flag is high for exactly one cycle per event.
- Reset (asynchronous assert, synchronous release): state WAIT_SOF, synced 0. All outputs 0: flags, latches, counters, snapshot, frame_cnt, line_cnt, beat_cnt.
- Reset mid-frame: tracking is lost. The checker waits for the next SOF with no errors.
- Back-to-back beats are supported every cycle. Stalls (tvalid without tready, or the reverse) never advance state.
- 1-beat lines (hsize ≤ PPC): tuser and tlast on the same beat is legal.

## Structure
- Package frame_chk_pkg holds:
  - ERR_EOL_EARLY=0, ERR_EOL_LATE=1, ERR_SOF_EARLY=2, ERR_SOF_LATE=3
  - state encoding WAIT_SOF/ACTIVE/DONE
  - a function for beats_per_line.
- Sub-module sat_counter (width param, inc, clr, saturating) is instantiated four times for err_cnt.

## Test plan
All scenarios use hsize=8, vsize=4, PPC=2 (4 beats/line).
- Two clean frames, random tready stalls -> no err_flag, frame_cnt=2, err_latch=0, state DONE.
- Beats before the first SOF, then a clean frame -> no errors, synced rises the cycle after the SOF beat.
- tlast on beat 2 of line 1 -> err_flag[0] one cycle. Snapshot: frame 1, line 1, beat 2, type 4'b0001. line_cnt=2.
- Line 0 sends 6 beats, tlast on the 6th -> err_flag[1] once (beat 3), err_cnt[1]=1. The next line is counted normally.
- tuser on line 2 beat 0 -> err_flag[2], frame restarts, frame_cnt += 1. A frame with an extra line -> err_flag[3], state WAIT_SOF.
- Force 2^ERR_CNT_W+3 eol_early events -> counter saturates. Then clr coincident with an error -> latches, counters and snapshot are 0, err_flag still pulses.
